mprc_meta_tag_check: RTL and testbench
======================================

Name: mprc_meta_tag_check

Overview:
- Downstream consumer of the 4-way, 64-set metadata array in the non-blocking data cache.
- Accepts lookup requests, issues the metadata read, and compares the request tag against all 4 ways.
- Produces a registered hit/miss result: one-hot hit way, hit coherence state, and a victim way with its tag and state for the refill/writeback path.
- 2-stage pipeline with valid/ready backpressure and same-cycle metadata-write forwarding.

Parameters:
- TAG_W, 20, tag width per way.
- IDX_W, 6, set index width (64 sets).
- COH_W, 2, coherence state width; value 0 = invalid.
- WAYS, 4, associativity. Fixed; other values unsupported.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active low
io_req_valid  in  1  lookup request valid
io_req_ready  out  1  lookup request accepted
io_req_bits_idx  in  IDX_W  set index
io_req_bits_tag  in  TAG_W  request tag
meta_read_valid  out  1  to metadata array read_valid
meta_read_ready  in  1  from metadata array read_ready
meta_read_bits_idx  out  IDX_W  read index
meta_read_bits_way_en  out  WAYS  read way enable, constant 4'hf
meta_resp_tag_0..3  in  TAG_W each  per-way tag from array
meta_resp_coh_state_0..3  in  COH_W each  per-way state from array
meta_write_valid  in  1  snooped array write valid
meta_write_bits_idx  in  IDX_W  snooped write index
meta_write_bits_way_en  in  WAYS  snooped write ways
meta_write_bits_data_tag  in  TAG_W  snooped write tag
meta_write_bits_data_coh_state  in  COH_W  snooped write state
io_resp_valid  out  1  result valid
io_resp_ready  in  1  result consumed
io_resp_bits_hit  out  1  any way hit
io_resp_bits_hit_way  out  WAYS  one-hot hit way
io_resp_bits_hit_state  out  COH_W  state of hit way, 0 on miss
io_resp_bits_victim_way  out  WAYS  one-hot replacement way
io_resp_bits_victim_tag  out  TAG_W  tag of victim way
io_resp_bits_victim_state  out  COH_W  state of victim way
io_resp_bits_idx  out  IDX_W  echoed index
io_resp_bits_tag  out  TAG_W  echoed request tag
io_err_multi_hit  out  1  sticky: more than one way hit

Behaviour:
- Reset (reset=0, async): s1_valid=0, s2_valid=0, LFSR=8'h01, io_err_multi_hit=0, all io_resp_bits=0. Reset mid-operation drops in-flight lookups; no flush is performed.
- Handshakes:
  - s1_fire = s1_valid & (!s2_valid | io_resp_ready).
  - io_req_ready = meta_read_ready & (!s1_valid | s1_fire).
  - meta_read_valid = io_req_valid & io_req_ready; meta_read_bits_idx = io_req_bits_idx (combinational).
  - Accept at edge T: s1 captures idx/tag, s1_valid=1. Array responds during cycle T+1 (s1).
- s1 evaluation (combinational on array resp): effective per-way tag/state = snooped write data when meta_write_valid & meta_write_bits_idx==s1_idx & way_en[w], else array resp.
- hit_w = (eff_tag_w==s1_tag) & (eff_state_w!=0).
  - hit_way = hit vector.
  - hit_state = state of the lowest-index hit way.
  - Popcount(hit)>1 at s1_fire sets io_err_multi_hit; it clears only on reset.
- Victim way: lowest-index way with eff_state==0. If all 4 ways are valid, use LFSR[1:0] as a binary index, converted to one-hot. victim_tag/state are taken from that way. Victim is computed on hits too.
- s1_fire: s2 captures all results plus idx/tag; s2_valid=1; s1_valid is cleared unless a new request is accepted the same cycle.
- Stall: while s1 holds, array resp tracks the RAM live, so writes land naturally. io_req_ready=0 so the array read index is not disturbed.
- s2 holds result while io_resp_valid & !io_resp_ready; outputs stable.
- s2_valid clears on handshake unless s1_fire in the same cycle.
- Writes to the s2 index are not reapplied to a held result; the consumer replays.
- LFSR: x^8+x^6+x^5+x^4+1, Fibonacci, shift left. Steps once per io_resp handshake with hit=0.
- Latency: request accepted T -> io_resp_valid at T+2. Full throughput is 1 lookup/cycle.
- meta_read_ready=0 (array init flush) forces io_req_ready=0. In-flight s1/s2 still drain.

Test Plan:
1. Reset, hold meta_read_ready=0 for 64 cycles, then 1 -> io_req_ready stays 0 until ready rises. After reset, LFSR=8'h01 and all outputs are 0.
2. Array resp ways 0..3 tags 20'h00010..00013, states 2'h1,1,1,1; request tag 20'h00012 at T -> at T+2 hit=1, hit_way=4'b0100, hit_state=2'h1.
3. Same set, request tag 20'h0ABCD, way 1 state 0 -> hit=0, victim_way=4'b0010, victim_state=0. With all ways valid -> victim_way=4'b0010 (LFSR=01), next miss uses the stepped LFSR.
4. Back-to-back 3 requests with io_resp_ready=0 for 4 cycles -> io_req_ready falls after the 2nd accept. Results emerge in order with no loss or duplication once ready=1.
5. In the s1 cycle, meta write idx matches with way_en=4'b0001, tag=req tag, state=2'h2 -> hit_way=4'b0001, hit_state=2'h2 despite the stale array resp.
6. Two ways share the request tag and both are valid -> io_err_multi_hit=1 and stays 1 across later lookups until reset.

Source files
------------

// File: rtl/mprc_meta_tag_check.sv
// Tag compare stage for the 4-way, 64-set data cache metadata array.
// Ports: io_req (lookup in), meta_read/meta_resp (array), meta_write (snoop), io_resp (hit/victim out), io_err_multi_hit.
module mprc_meta_tag_check #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 6,
  parameter int COH_W = 2,
  parameter int WAYS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [IDX_W-1:0] io_req_bits_idx,
  input  logic [TAG_W-1:0] io_req_bits_tag,
  output logic             meta_read_valid,
  input  logic             meta_read_ready,
  output logic [IDX_W-1:0] meta_read_bits_idx,
  output logic [WAYS-1:0]  meta_read_bits_way_en,
  input  logic [TAG_W-1:0] meta_resp_tag_0,
  input  logic [TAG_W-1:0] meta_resp_tag_1,
  input  logic [TAG_W-1:0] meta_resp_tag_2,
  input  logic [TAG_W-1:0] meta_resp_tag_3,
  input  logic [COH_W-1:0] meta_resp_coh_state_0,
  input  logic [COH_W-1:0] meta_resp_coh_state_1,
  input  logic [COH_W-1:0] meta_resp_coh_state_2,
  input  logic [COH_W-1:0] meta_resp_coh_state_3,
  input  logic             meta_write_valid,
  input  logic [IDX_W-1:0] meta_write_bits_idx,
  input  logic [WAYS-1:0]  meta_write_bits_way_en,
  input  logic [TAG_W-1:0] meta_write_bits_data_tag,
  input  logic [COH_W-1:0] meta_write_bits_data_coh_state,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic             io_resp_bits_hit,
  output logic [WAYS-1:0]  io_resp_bits_hit_way,
  output logic [COH_W-1:0] io_resp_bits_hit_state,
  output logic [WAYS-1:0]  io_resp_bits_victim_way,
  output logic [TAG_W-1:0] io_resp_bits_victim_tag,
  output logic [COH_W-1:0] io_resp_bits_victim_state,
  output logic [IDX_W-1:0] io_resp_bits_idx,
  output logic [TAG_W-1:0] io_resp_bits_tag,
  output logic             io_err_multi_hit
);

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic [7:0]       lfsr;

  logic s1_fire;
  logic req_fire;
  logic resp_fire;

  assign s1_fire   = s1_valid & (~s2_valid | io_resp_ready);
  assign io_req_ready =
    meta_read_ready & (~s1_valid | s1_fire);
  assign req_fire  = io_req_valid & io_req_ready;
  assign resp_fire = s2_valid & io_resp_ready;

  assign meta_read_valid       = req_fire;
  assign meta_read_bits_idx    = io_req_bits_idx;
  assign meta_read_bits_way_en = '1;
  assign io_resp_valid         = s2_valid;

  logic [TAG_W-1:0] rsp_tag [WAYS];
  logic [COH_W-1:0] rsp_st  [WAYS];

  assign rsp_tag[0] = meta_resp_tag_0;
  assign rsp_tag[1] = meta_resp_tag_1;
  assign rsp_tag[2] = meta_resp_tag_2;
  assign rsp_tag[3] = meta_resp_tag_3;
  assign rsp_st[0]  = meta_resp_coh_state_0;
  assign rsp_st[1]  = meta_resp_coh_state_1;
  assign rsp_st[2]  = meta_resp_coh_state_2;
  assign rsp_st[3]  = meta_resp_coh_state_3;

  logic [TAG_W-1:0] eff_tag [WAYS];
  logic [COH_W-1:0] eff_st  [WAYS];
  logic [WAYS-1:0]  fwd;
  logic [WAYS-1:0]  hit;
  logic [WAYS-1:0]  inv;

  // A write landing on the s1 set this cycle is newer than the array data.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      fwd[w] = meta_write_valid &
               (meta_write_bits_idx == s1_idx) &
               meta_write_bits_way_en[w];
      eff_tag[w] = fwd[w] ?
        meta_write_bits_data_tag : rsp_tag[w];
      eff_st[w] = fwd[w] ?
        meta_write_bits_data_coh_state : rsp_st[w];
      hit[w] = (eff_tag[w] == s1_tag) &
               (eff_st[w] != '0);
      inv[w] = (eff_st[w] == '0);
    end
  end

  logic [COH_W-1:0] hit_st;

  always_comb begin
    hit_st = '0;
    priority case (1'b1)
      hit[0]:  hit_st = eff_st[0];
      hit[1]:  hit_st = eff_st[1];
      hit[2]:  hit_st = eff_st[2];
      hit[3]:  hit_st = eff_st[3];
      default: hit_st = '0;
    endcase
  end

  logic [1:0]       vic_sel;
  logic [WAYS-1:0]  vic_way;
  logic [TAG_W-1:0] vic_tag;
  logic [COH_W-1:0] vic_st;

  // Prefer an empty way; fall back to pseudo-random when the set is full.
  always_comb begin
    vic_sel = lfsr[1:0];
    priority case (1'b1)
      inv[0]:  vic_sel = 2'd0;
      inv[1]:  vic_sel = 2'd1;
      inv[2]:  vic_sel = 2'd2;
      inv[3]:  vic_sel = 2'd3;
      default: vic_sel = lfsr[1:0];
    endcase
  end

  assign vic_way = WAYS'(1) << vic_sel;
  assign vic_tag = eff_tag[vic_sel];
  assign vic_st  = eff_st[vic_sel];

  logic multi;
  assign multi = |(hit & (hit - WAYS'(1)));

  logic lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_tag   <= '0;
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_idx   <= io_req_bits_idx;
      s1_tag   <= io_req_bits_tag;
    end else if (s1_fire) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid                  <= 1'b0;
      io_resp_bits_hit          <= 1'b0;
      io_resp_bits_hit_way      <= '0;
      io_resp_bits_hit_state    <= '0;
      io_resp_bits_victim_way   <= '0;
      io_resp_bits_victim_tag   <= '0;
      io_resp_bits_victim_state <= '0;
      io_resp_bits_idx          <= '0;
      io_resp_bits_tag          <= '0;
    end else if (s1_fire) begin
      s2_valid                  <= 1'b1;
      io_resp_bits_hit          <= |hit;
      io_resp_bits_hit_way      <= hit;
      io_resp_bits_hit_state    <= hit_st;
      io_resp_bits_victim_way   <= vic_way;
      io_resp_bits_victim_tag   <= vic_tag;
      io_resp_bits_victim_state <= vic_st;
      io_resp_bits_idx          <= s1_idx;
      io_resp_bits_tag          <= s1_tag;
    end else if (resp_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_err_multi_hit <= 1'b0;
    end else if (s1_fire && multi) begin
      io_err_multi_hit <= 1'b1;
    end
  end

  // Replacement state only advances when a miss is handed off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'h01;
    end else if (resp_fire && !io_resp_bits_hit) begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

endmodule

// File: tb/tb_mprc_meta_tag_check.sv
// Bench for mprc_meta_tag_check: array model, table vectors, scoreboard.
// Ports: none (top-level bench).
module tb_mprc_meta_tag_check;

  localparam int TW = 20;
  localparam int IW = 6;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          io_req_valid;
  logic          io_req_ready;
  logic [IW-1:0] io_req_bits_idx;
  logic [TW-1:0] io_req_bits_tag;
  logic          meta_read_valid;
  logic          meta_read_ready;
  logic [IW-1:0] meta_read_bits_idx;
  logic [3:0]    meta_read_bits_way_en;
  logic          meta_write_valid;
  logic [IW-1:0] meta_write_bits_idx;
  logic [3:0]    meta_write_bits_way_en;
  logic [TW-1:0] meta_write_bits_data_tag;
  logic [CW-1:0] meta_write_bits_data_coh_state;
  logic          io_resp_valid;
  logic          io_resp_ready;
  logic          io_resp_bits_hit;
  logic [3:0]    io_resp_bits_hit_way;
  logic [CW-1:0] io_resp_bits_hit_state;
  logic [3:0]    io_resp_bits_victim_way;
  logic [TW-1:0] io_resp_bits_victim_tag;
  logic [CW-1:0] io_resp_bits_victim_state;
  logic [IW-1:0] io_resp_bits_idx;
  logic [TW-1:0] io_resp_bits_tag;
  logic          io_err_multi_hit;

  logic [TW-1:0] mtag [64][4];
  logic [CW-1:0] mst  [64][4];
  logic [IW-1:0] rd_idx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx <= '0;
      for (int i = 0; i < 64; i++)
        for (int w = 0; w < 4; w++) begin
          mtag[i][w] <= '0;
          mst[i][w]  <= '0;
        end
    end else begin
      if (meta_write_valid)
        for (int w = 0; w < 4; w++)
          if (meta_write_bits_way_en[w]) begin
            mtag[meta_write_bits_idx][w] <= meta_write_bits_data_tag;
            mst[meta_write_bits_idx][w]  <= meta_write_bits_data_coh_state;
          end
      if (meta_read_valid) rd_idx <= meta_read_bits_idx;
    end
  end

  mprc_meta_tag_check dut (
    .clk                            (clk),
    .reset                          (reset),
    .io_req_valid                   (io_req_valid),
    .io_req_ready                   (io_req_ready),
    .io_req_bits_idx                (io_req_bits_idx),
    .io_req_bits_tag                (io_req_bits_tag),
    .meta_read_valid                (meta_read_valid),
    .meta_read_ready                (meta_read_ready),
    .meta_read_bits_idx             (meta_read_bits_idx),
    .meta_read_bits_way_en          (meta_read_bits_way_en),
    .meta_resp_tag_0                (mtag[rd_idx][0]),
    .meta_resp_tag_1                (mtag[rd_idx][1]),
    .meta_resp_tag_2                (mtag[rd_idx][2]),
    .meta_resp_tag_3                (mtag[rd_idx][3]),
    .meta_resp_coh_state_0          (mst[rd_idx][0]),
    .meta_resp_coh_state_1          (mst[rd_idx][1]),
    .meta_resp_coh_state_2          (mst[rd_idx][2]),
    .meta_resp_coh_state_3          (mst[rd_idx][3]),
    .meta_write_valid               (meta_write_valid),
    .meta_write_bits_idx            (meta_write_bits_idx),
    .meta_write_bits_way_en         (meta_write_bits_way_en),
    .meta_write_bits_data_tag       (meta_write_bits_data_tag),
    .meta_write_bits_data_coh_state (meta_write_bits_data_coh_state),
    .io_resp_valid                  (io_resp_valid),
    .io_resp_ready                  (io_resp_ready),
    .io_resp_bits_hit               (io_resp_bits_hit),
    .io_resp_bits_hit_way           (io_resp_bits_hit_way),
    .io_resp_bits_hit_state         (io_resp_bits_hit_state),
    .io_resp_bits_victim_way        (io_resp_bits_victim_way),
    .io_resp_bits_victim_tag        (io_resp_bits_victim_tag),
    .io_resp_bits_victim_state      (io_resp_bits_victim_state),
    .io_resp_bits_idx               (io_resp_bits_idx),
    .io_resp_bits_tag               (io_resp_bits_tag),
    .io_err_multi_hit               (io_err_multi_hit)
  );

  typedef struct {
    int            id;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic [3:0]    hw;
    logic [CW-1:0] hs;
    logic [3:0]    vw;
    logic [TW-1:0] vt;
    logic [CW-1:0] vs;
    logic          err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acyc;
  } sb_t;

  vec_t reqq [$];
  sb_t  sb [$];
  vec_t tbl [8];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc = 0;
  int acc_base = 0;
  int rr_hold = 0;
  bit wr_next = 1'b0;
  bit fwd_arm = 1'b0;
  bit chk_lat = 1'b0;
  bit chk2 = 1'b0;

  function automatic vec_t mk(
    int id, logic [IW-1:0] idx, logic [TW-1:0] tag,
    logic hit, logic [3:0] hw, logic [CW-1:0] hs,
    logic [3:0] vw, logic [TW-1:0] vt, logic [CW-1:0] vs,
    logic err);
    vec_t v;
    v.id = id; v.idx = idx; v.tag = tag;
    v.hit = hit; v.hw = hw; v.hs = hs;
    v.vw = vw; v.vt = vt; v.vs = vs; v.err = err;
    return v;
  endfunction

  task automatic check_resp();
    sb_t e;
    int  lat;
    bit  bad;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_resp: got resp idx=%0d tag=%h, want no response",
               io_resp_bits_idx, io_resp_bits_tag);
    end else begin
      e = sb.pop_front();
      lat = cyc - e.acyc;
      bad = (io_resp_bits_hit !== e.v.hit) ||
            (io_resp_bits_hit_way !== e.v.hw) ||
            (io_resp_bits_hit_state !== e.v.hs) ||
            (io_resp_bits_victim_way !== e.v.vw) ||
            (io_resp_bits_victim_tag !== e.v.vt) ||
            (io_resp_bits_victim_state !== e.v.vs) ||
            (io_resp_bits_idx !== e.v.idx) ||
            (io_resp_bits_tag !== e.v.tag) ||
            (io_err_multi_hit !== e.v.err) ||
            (chk_lat && lat != 2);
      if (bad) begin
        n_bad++;
        $display("FAIL vec%0d: got hit=%b hw=%b hs=%0h vw=%b vt=%h vs=%0h idx=%0d tag=%h err=%b lat=%0d; want hit=%b hw=%b hs=%0h vw=%b vt=%h vs=%0h idx=%0d tag=%h err=%b lat=2",
                 e.v.id, io_resp_bits_hit, io_resp_bits_hit_way,
                 io_resp_bits_hit_state, io_resp_bits_victim_way,
                 io_resp_bits_victim_tag, io_resp_bits_victim_state,
                 io_resp_bits_idx, io_resp_bits_tag, io_err_multi_hit, lat,
                 e.v.hit, e.v.hw, e.v.hs, e.v.vw, e.v.vt, e.v.vs,
                 e.v.idx, e.v.tag, e.v.err);
      end
    end
  endtask

  task automatic cycle();
    sb_t e;
    if (reqq.size() != 0) begin
      io_req_valid    = 1'b1;
      io_req_bits_idx = reqq[0].idx;
      io_req_bits_tag = reqq[0].tag;
    end else begin
      io_req_valid = 1'b0;
    end
    io_resp_ready = (rr_hold == 0);
    if (rr_hold > 0) rr_hold--;
    meta_write_valid = wr_next;
    wr_next = 1'b0;
    #1;
    if (io_resp_valid && io_resp_ready) check_resp();
    if (chk2 && acc == acc_base + 2) begin
      chk2 = 1'b0;
      n_vec++;
      if (io_req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL req_ready_stall: got %b want 0", io_req_ready);
      end
    end
    if (io_req_valid && io_req_ready) begin
      e.v = reqq.pop_front();
      e.acyc = cyc;
      sb.push_back(e);
      acc++;
      if (fwd_arm) begin
        fwd_arm = 1'b0;
        wr_next = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((reqq.size() != 0 || sb.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    n_vec++;
    if (reqq.size() != 0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unsent, %0d outstanding; want 0, 0",
               reqq.size(), sb.size());
      reqq.delete();
      sb.delete();
    end
  endtask

  task automatic mwrite(input logic [IW-1:0] idx, input int way,
                        input logic [TW-1:0] tag, input logic [CW-1:0] st);
    io_req_valid = 1'b0;
    meta_write_valid = 1'b1;
    meta_write_bits_idx = idx;
    meta_write_bits_way_en = 4'b0001 << way;
    meta_write_bits_data_tag = tag;
    meta_write_bits_data_coh_state = st;
    @(posedge clk);
    #1;
    meta_write_valid = 1'b0;
  endtask

  task automatic fill(input logic [IW-1:0] idx, input logic [TW-1:0] base,
                      input logic [7:0] sts);
    for (int w = 0; w < 4; w++)
      mwrite(idx, w, base + TW'(w), sts[2*w +: 2]);
  endtask

  function automatic bit outs_zero();
    return (io_resp_valid === 1'b0) && (io_resp_bits_hit === 1'b0) &&
           (io_resp_bits_hit_way === '0) && (io_resp_bits_hit_state === '0) &&
           (io_resp_bits_victim_way === '0) && (io_resp_bits_victim_tag === '0) &&
           (io_resp_bits_victim_state === '0) && (io_resp_bits_idx === '0) &&
           (io_resp_bits_tag === '0) && (io_err_multi_hit === 1'b0);
  endfunction

  initial begin
    int stuck;
    tbl[0] = mk(0, 6'd5, 20'h00012, 1, 4'b0100, 2'h1, 4'b0010, 20'h00011, 2'h1, 0);
    tbl[1] = mk(1, 6'd5, 20'h0ABCD, 0, 4'b0000, 2'h0, 4'b0010, 20'h00011, 2'h1, 0);
    tbl[2] = mk(2, 6'd5, 20'h0BEEF, 0, 4'b0000, 2'h0, 4'b0100, 20'h00012, 2'h1, 0);
    tbl[3] = mk(3, 6'd6, 20'h0ABCD, 0, 4'b0000, 2'h0, 4'b0010, 20'h00011, 2'h0, 0);
    tbl[4] = mk(4, 6'd5, 20'h00013, 1, 4'b1000, 2'h1, 4'b0001, 20'h00010, 2'h1, 0);
    tbl[5] = mk(5, 6'd5, 20'h00777, 0, 4'b0000, 2'h0, 4'b0001, 20'h00010, 2'h1, 0);
    tbl[6] = mk(6, 6'd5, 20'h00888, 0, 4'b0000, 2'h0, 4'b0010, 20'h00011, 2'h1, 0);
    tbl[7] = mk(7, 6'd9, 20'h00000, 0, 4'b0000, 2'h0, 4'b0001, 20'h00000, 2'h0, 0);

    reset = 1'b0;
    io_req_valid = 1'b0;
    io_req_bits_idx = '0;
    io_req_bits_tag = '0;
    io_resp_ready = 1'b1;
    meta_read_ready = 1'b0;
    meta_write_valid = 1'b0;
    meta_write_bits_idx = '0;
    meta_write_bits_way_en = '0;
    meta_write_bits_data_tag = '0;
    meta_write_bits_data_coh_state = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (!outs_zero()) begin
      n_bad++;
      $display("FAIL reset_outs: got valid=%b hit=%b vw=%b err=%b; want all 0",
               io_resp_valid, io_resp_bits_hit, io_resp_bits_victim_way,
               io_err_multi_hit);
    end
    reset = 1'b1;

    // Array still flushing: no request may be taken.
    stuck = 0;
    io_req_valid = 1'b1;
    io_req_bits_idx = 6'd3;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (io_req_ready !== 1'b0 || meta_read_valid !== 1'b0) stuck++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (stuck != 0) begin
      n_bad++;
      $display("FAIL flush_ready: got %0d cycles with ready high, want 0", stuck);
    end
    meta_read_ready = 1'b1;
    #1;
    n_vec++;
    if (io_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_rise: got %b want 1", io_req_ready);
    end
    io_req_valid = 1'b0;
    @(posedge clk);
    #1;

    fill(6'd5, 20'h00010, 8'h55);
    fill(6'd6, 20'h00010, 8'h51);
    fill(6'd8, 20'h00500, 8'h00);
    mwrite(6'd7, 0, 20'h00100, 2'h1);
    mwrite(6'd7, 1, 20'h00200, 2'h1);
    mwrite(6'd7, 2, 20'h00100, 2'h1);
    mwrite(6'd7, 3, 20'h00300, 2'h0);

    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      reqq.push_back(tbl[i]);
      drain(20);
    end
    chk_lat = 1'b0;

    reqq.push_back(mk(10, 6'd6, 20'h00010, 1, 4'b0001, 2'h1, 4'b0010, 20'h00011, 2'h0, 0));
    reqq.push_back(mk(11, 6'd6, 20'h00012, 1, 4'b0100, 2'h1, 4'b0010, 20'h00011, 2'h0, 0));
    reqq.push_back(mk(12, 6'd6, 20'h00013, 1, 4'b1000, 2'h1, 4'b0010, 20'h00011, 2'h0, 0));
    rr_hold = 4;
    acc_base = acc;
    chk2 = 1'b1;
    drain(40);
    if (chk2) begin
      chk2 = 1'b0;
      n_vec++;
      n_bad++;
      $display("FAIL req_ready_stall: got never reached, want checked");
    end

    meta_write_bits_idx = 6'd8;
    meta_write_bits_way_en = 4'b0001;
    meta_write_bits_data_tag = 20'h00777;
    meta_write_bits_data_coh_state = 2'h2;
    fwd_arm = 1'b1;
    reqq.push_back(mk(20, 6'd8, 20'h00777, 1, 4'b0001, 2'h2, 4'b0010, 20'h00501, 2'h0, 0));
    drain(20);

    reqq.push_back(mk(30, 6'd7, 20'h00100, 1, 4'b0101, 2'h1, 4'b1000, 20'h00300, 2'h0, 1));
    drain(20);
    reqq.push_back(mk(31, 6'd6, 20'h00010, 1, 4'b0001, 2'h1, 4'b0010, 20'h00011, 2'h0, 1));
    drain(20);

    reset = 1'b0;
    #1;
    n_vec++;
    if (!outs_zero()) begin
      n_bad++;
      $display("FAIL reset_clear: got valid=%b hit=%b err=%b; want all 0",
               io_resp_valid, io_resp_bits_hit, io_err_multi_hit);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
